// File: rtl/uart_boot_loader.sv
// Polls an MMIO UART, loads A5-framed images into instruction memory, ACK/NAKs the host, releases the CPU.
// One UART access per 2 cycles min; mem_we held until mem_ready (no UART traffic while stalled).
module uart_boot_loader #(
  parameter logic [31:0] UART_BASE = 32'h1000_0000,
  parameter int          TIMEOUT   = 1_000_000,
  parameter bit          AUTOSTART = 1'b1
) (
  input  logic        CLOCK_50MHz,
  input  logic        RESET_L,
  input  logic        start,
  output logic        u_AS_L,
  output logic        u_WE_L,
  output logic [31:0] u_Address,
  output logic [7:0]  u_DataOut,
  input  logic [7:0]  u_DataIn,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        cpu_run
);

  localparam logic [7:0]  SYNC     = 8'hA5;
  localparam logic [7:0]  ACK      = 8'h06;
  localparam logic [7:0]  NAK      = 8'h15;
  localparam logic [7:0]  CLR_MASK = 8'h0C;
  localparam logic [31:0] REG_DATA = UART_BASE;
  localparam logic [31:0] REG_STAT = UART_BASE + 32'd1;
  localparam int          TW       = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {S_IDLE, S_CLR, S_POLL, S_RDATA, S_MEMWR, S_TXPOLL, S_TXW} state_t;
  typedef enum logic [2:0] {F_HUNT, F_ADDR, F_NW, F_DATA, F_CSUM} field_t;

  state_t         state_q, state_d;
  field_t         field_q;
  logic           gap_q, auto_q, ack_q;
  logic [1:0]     bidx_q;
  logic [31:0]    addr_q, wdata_q;
  logic [7:0]     nw_lo_q, csum_q;
  logic [15:0]    words_q;
  logic [TW-1:0]  tmo_q;
  logic           done_q, err_q, run_q;
  logic           byte_rd, nak_now, tx_fire, go;
  logic           tmo_run, tmo_hit;
  logic [15:0]    nw_new;

  assign nw_new  = {u_DataIn, nw_lo_q};
  assign tmo_run = (field_q != F_HUNT) && (state_q == S_POLL || state_q == S_RDATA);
  assign tmo_hit = tmo_run && (tmo_q >= TW'(TIMEOUT));
  assign go      = (state_q == S_IDLE) && (state_d == S_CLR);

  // Every access state strobes only when the previous cycle was idle on the bus.
  always_comb begin
    state_d   = state_q;
    u_AS_L    = 1'b1;
    u_WE_L    = 1'b1;
    u_Address = UART_BASE;
    u_DataOut = 8'h00;
    byte_rd   = 1'b0;
    nak_now   = 1'b0;
    tx_fire   = 1'b0;
    case (state_q)
      S_IDLE: if (start || auto_q) state_d = S_CLR;
      S_CLR: if (!gap_q) begin
        u_AS_L    = 1'b0;
        u_WE_L    = 1'b0;
        u_Address = REG_STAT;
        u_DataOut = CLR_MASK;
        state_d   = S_POLL;
      end
      S_POLL: if (tmo_hit) begin
        nak_now = 1'b1;
        state_d = S_TXPOLL;
      end else if (!gap_q) begin
        u_AS_L    = 1'b0;
        u_Address = REG_STAT;
        if (field_q != F_HUNT && (u_DataIn[3] || u_DataIn[2])) begin
          nak_now = 1'b1;
          state_d = S_TXPOLL;
        end else if (u_DataIn[1]) begin
          state_d = S_RDATA;
        end
      end
      S_RDATA: if (!gap_q) begin
        u_AS_L    = 1'b0;
        u_Address = REG_DATA;
        byte_rd   = 1'b1;
        if (field_q == F_CSUM)                         state_d = S_TXPOLL;
        else if (field_q == F_DATA && bidx_q == 2'd3)  state_d = S_MEMWR;
        else                                           state_d = S_POLL;
      end
      S_MEMWR: if (mem_ready) state_d = S_POLL;
      S_TXPOLL: if (!gap_q) begin
        u_AS_L    = 1'b0;
        u_Address = REG_STAT;
        if (u_DataIn[0]) state_d = S_TXW;
      end
      S_TXW: if (!gap_q) begin
        u_AS_L    = 1'b0;
        u_WE_L    = 1'b0;
        u_Address = REG_DATA;
        u_DataOut = ack_q ? ACK : NAK;
        tx_fire   = 1'b1;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50MHz or negedge RESET_L) begin
    if (!RESET_L) begin
      state_q <= S_IDLE;
      gap_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gap_q   <= ~u_AS_L;
    end
  end

  always_ff @(posedge CLOCK_50MHz or negedge RESET_L) begin
    if (!RESET_L) begin
      auto_q  <= AUTOSTART;
      field_q <= F_HUNT;
      bidx_q  <= 2'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      nw_lo_q <= 8'd0;
      words_q <= 16'd0;
      csum_q  <= 8'd0;
      tmo_q   <= '0;
      ack_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      run_q   <= 1'b0;
    end else begin
      if (go) begin
        auto_q  <= 1'b0;
        field_q <= F_HUNT;
        bidx_q  <= 2'd0;
        ack_q   <= 1'b0;
        done_q  <= 1'b0;
        err_q   <= 1'b0;
        tmo_q   <= '0;
      end
      if (byte_rd) begin
        tmo_q <= '0;
        case (field_q)
          F_HUNT: if (u_DataIn == SYNC) begin
            field_q <= F_ADDR;
            bidx_q  <= 2'd0;
            csum_q  <= 8'd0;
          end
          F_ADDR: begin
            addr_q <= {u_DataIn, addr_q[31:8]};
            csum_q <= csum_q + u_DataIn;
            bidx_q <= bidx_q + 2'd1;
            if (bidx_q == 2'd3) field_q <= F_NW;
          end
          F_NW: begin
            csum_q  <= csum_q + u_DataIn;
            nw_lo_q <= u_DataIn;
            if (bidx_q == 2'd1) begin
              bidx_q  <= 2'd0;
              words_q <= nw_new;
              field_q <= (nw_new == 16'd0) ? F_CSUM : F_DATA;
            end else begin
              bidx_q <= bidx_q + 2'd1;
            end
          end
          F_DATA: begin
            wdata_q <= {u_DataIn, wdata_q[31:8]};
            csum_q  <= csum_q + u_DataIn;
            bidx_q  <= bidx_q + 2'd1;
          end
          F_CSUM:  ack_q <= (u_DataIn == csum_q);
          default: ;
        endcase
      end else if (tmo_run && tmo_q < TW'(TIMEOUT)) begin
        tmo_q <= tmo_q + 1'b1;
      end
      if (nak_now) ack_q <= 1'b0;
      // Words commit as they complete; a later bad checksum does not undo them.
      if (state_q == S_MEMWR && mem_ready) begin
        addr_q  <= addr_q + 32'd4;
        words_q <= words_q - 16'd1;
        field_q <= (words_q == 16'd1) ? F_CSUM : F_DATA;
      end
      if (tx_fire) begin
        done_q <= ack_q;
        err_q  <= ~ack_q;
        if (ack_q) run_q <= 1'b1;
      end
    end
  end

  assign mem_we    = (state_q == S_MEMWR);
  assign mem_addr  = addr_q & ~32'd3;
  assign mem_wdata = wdata_q;
  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign err       = err_q;
  assign cpu_run   = run_q;

endmodule

// File: tb/tb_uart_boot_loader.sv
// Bench for uart_boot_loader: behavioural UART on the register bus plus memory/tx scoreboards.
module tb_uart_boot_loader;

  localparam logic [31:0] BASE = 32'h1000_0000;
  localparam int          TMO  = 100;

  logic        clk = 1'b0;
  logic        rst_l = 1'b1;
  logic        start = 1'b0;
  logic        as_l, we_l;
  logic [31:0] uaddr;
  logic [7:0]  dout;
  logic [7:0]  din = 8'h00;
  logic        mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_ready = 1'b1;
  logic        busy, done, err, cpu_run;

  always #10 clk = ~clk;

  uart_boot_loader #(.UART_BASE(BASE), .TIMEOUT(TMO), .AUTOSTART(1'b1)) dut (
    .CLOCK_50MHz(clk), .RESET_L(rst_l), .start(start),
    .u_AS_L(as_l), .u_WE_L(we_l), .u_Address(uaddr), .u_DataOut(dout), .u_DataIn(din),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
    .busy(busy), .done(done), .err(err), .cpu_run(cpu_run)
  );

  int tests = 0;
  int fails = 0;
  logic [7:0]  rx_q[$];
  logic [7:0]  tx_exp[$];
  logic [63:0] mem_exp[$];
  int          tx_cnt = 0, clr_cnt = 0, viol = 0;
  logic        prev_as_low = 1'b0;
  logic [63:0] m_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // UART register model and memory scoreboard; read data is presented for the strobed cycle.
  always @(negedge clk) begin
    if (!as_l && prev_as_low) viol <= viol + 1;
    prev_as_low <= !as_l;
    din <= 8'h00;
    if (!as_l && we_l) begin
      if (uaddr == BASE) begin
        if (rx_q.size() > 0) din <= rx_q.pop_front();
        else viol <= viol + 1;
      end else begin
        din <= {6'b0, rx_q.size() > 0, 1'b1};
      end
    end
    if (!as_l && !we_l) begin
      if (uaddr == BASE) begin
        tx_cnt <= tx_cnt + 1;
        check("tx_expected_present", 32'(tx_exp.size() != 0), 1);
        if (tx_exp.size() != 0) check("tx_byte", 32'(dout), 32'(tx_exp.pop_front()));
      end else begin
        clr_cnt <= clr_cnt + 1;
        check("clr_addr", uaddr, BASE + 32'd1);
        check("clr_data", 32'(dout), 32'h0C);
      end
    end
    if (mem_we && mem_ready) begin
      check("mem_expected_present", 32'(mem_exp.size() != 0), 1);
      if (mem_exp.size() != 0) begin
        m_e = mem_exp.pop_front();
        check("mem_addr", mem_addr, m_e[63:32]);
        check("mem_wdata", mem_wdata, m_e[31:0]);
      end
    end
  end

  typedef struct {
    logic [31:0] addr;
    int          nw;
    logic [31:0] w0, w1;
    logic [7:0]  cdelta;
    bit          garbage, mid_start;
    logic [7:0]  exp_tx;
    bit          exp_done, exp_err, exp_run;
  } vec_t;

  function automatic vec_t mk(logic [31:0] a, int n, logic [31:0] w0, logic [31:0] w1,
                              logic [7:0] cd, bit g, bit ms, logic [7:0] tx, bit d, bit e, bit r);
    vec_t v;
    v.addr = a; v.nw = n; v.w0 = w0; v.w1 = w1; v.cdelta = cd; v.garbage = g;
    v.mid_start = ms; v.exp_tx = tx; v.exp_done = d; v.exp_err = e; v.exp_run = r;
    return v;
  endfunction

  // Queues the host byte stream; max_data < 0 means a complete frame with checksum.
  task automatic push_frame(input vec_t v, input int max_data, input bit push_mem);
    logic [7:0]  cs;
    logic [31:0] w;
    logic [15:0] nw16;
    int          sent;
    cs = 8'h00; sent = 0; nw16 = 16'(v.nw);
    if (v.garbage) begin rx_q.push_back(8'h00); rx_q.push_back(8'hFF); rx_q.push_back(8'h5A); end
    rx_q.push_back(8'hA5);
    for (int k = 0; k < 4; k++) begin rx_q.push_back(v.addr[8*k +: 8]); cs += v.addr[8*k +: 8]; end
    for (int k = 0; k < 2; k++) begin rx_q.push_back(nw16[8*k +: 8]); cs += nw16[8*k +: 8]; end
    for (int i = 0; i < v.nw; i++) begin
      w = (i == 0) ? v.w0 : v.w1;
      for (int k = 0; k < 4; k++) begin
        if (max_data < 0 || sent < max_data) begin
          rx_q.push_back(w[8*k +: 8]); cs += w[8*k +: 8]; sent++;
        end
      end
      if (push_mem) mem_exp.push_back({(v.addr & ~32'd3) + 32'(4 * i), w});
    end
    if (max_data < 0) rx_q.push_back(cs + v.cdelta);
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int tx_target, output int cycles);
    cycles = 0;
    while (cycles < 4000 && !(tx_cnt == tx_target && !busy)) begin
      @(negedge clk);
      cycles++;
    end
    check({name, "_completed"}, 32'(cycles < 4000), 1);
    @(negedge clk);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_as_l"}, 32'(as_l), 1);
    check({tag, "_we_l"}, 32'(we_l), 1);
    check({tag, "_uaddr"}, uaddr, BASE);
    check({tag, "_dout"}, 32'(dout), 0);
    check({tag, "_mem_we"}, 32'(mem_we), 0);
    check({tag, "_mem_addr"}, mem_addr, 0);
    check({tag, "_mem_wdata"}, mem_wdata, 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_done"}, 32'(done), 0);
    check({tag, "_err"}, 32'(err), 0);
    check({tag, "_cpu_run"}, 32'(cpu_run), 0);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v[6];
    vec_t h;
    int   tx0, clr0, cyc, n;
    logic [31:0] a0, d0;
    bit   stable;

    v[0] = mk(32'h0000_0100, 2, 32'h4433_2211, 32'h8877_6655, 8'h01, 0, 0, 8'h15, 0, 1, 0);
    v[1] = mk(32'h0000_0100, 2, 32'h4433_2211, 32'h8877_6655, 8'h00, 0, 0, 8'h06, 1, 0, 1);
    v[2] = mk(32'h0000_2000, 0, 32'h0,         32'h0,         8'h00, 1, 1, 8'h06, 1, 0, 1);
    v[3] = mk(32'h0000_3003, 1, 32'hDEAD_BEEF, 32'h0,         8'h00, 0, 0, 8'h06, 1, 0, 1);
    v[4] = mk(32'hFFFF_FFFC, 2, 32'h0102_0304, 32'hA5A5_A5A5, 8'h00, 1, 0, 8'h06, 1, 0, 1);
    v[5] = mk(32'h0000_0400, 1, 32'hCAFE_F00D, 32'h0,         8'h80, 0, 0, 8'h15, 0, 1, 1);

    #1 rst_l = 1'b0;
    repeat (3) @(negedge clk);
    check_reset("reset");
    tx0 = tx_cnt; clr0 = clr_cnt;
    @(posedge clk); #1 rst_l = 1'b1;
    repeat (2) @(negedge clk);
    check("autostart_busy", 32'(busy), 1);

    for (int i = 0; i < 6; i++) begin
      if (i != 0) begin tx0 = tx_cnt; clr0 = clr_cnt; end
      tx_exp.push_back(v[i].exp_tx);
      push_frame(v[i], -1, 1'b1);
      if (i != 0) pulse_start();
      if (v[i].mid_start) begin repeat (15) @(negedge clk); pulse_start(); end
      wait_done($sformatf("vec%0d", i), tx0 + 1, cyc);
      check($sformatf("vec%0d_tx_count", i), 32'(tx_cnt - tx0), 1);
      check($sformatf("vec%0d_clr_count", i), 32'(clr_cnt - clr0), 1);
      check($sformatf("vec%0d_done", i), 32'(done), 32'(v[i].exp_done));
      check($sformatf("vec%0d_err", i), 32'(err), 32'(v[i].exp_err));
      check($sformatf("vec%0d_cpu_run", i), 32'(cpu_run), 32'(v[i].exp_run));
      check($sformatf("vec%0d_busy", i), 32'(busy), 0);
      check($sformatf("vec%0d_mem_left", i), 32'(mem_exp.size()), 0);
    end

    // Memory stall on the first word.
    h = mk(32'h0000_0500, 2, 32'h1234_5678, 32'h9ABC_DEF0, 8'h00, 0, 0, 8'h06, 1, 0, 1);
    @(posedge clk); #1 mem_ready = 1'b0;
    tx0 = tx_cnt;
    tx_exp.push_back(8'h06);
    push_frame(h, -1, 1'b1);
    pulse_start();
    n = 0;
    while (n < 2000 && !mem_we) begin @(negedge clk); n++; end
    check("stall_mem_we_seen", 32'(n < 2000), 1);
    a0 = mem_addr; d0 = mem_wdata;
    check("stall_addr", a0, 32'h0000_0500);
    check("stall_data", d0, 32'h1234_5678);
    stable = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (!mem_we || mem_addr !== a0 || mem_wdata !== d0 || as_l !== 1'b1) stable = 1'b0;
    end
    check("stall_stable", 32'(stable), 1);
    @(posedge clk); #1 mem_ready = 1'b1;
    wait_done("stall", tx0 + 1, cyc);
    check("stall_done", 32'(done), 1);
    check("stall_mem_left", 32'(mem_exp.size()), 0);

    // Host stalls after three data bytes.
    h = mk(32'h0000_0600, 2, 32'h1111_1111, 32'h2222_2222, 8'h00, 0, 0, 8'h15, 0, 1, 1);
    tx0 = tx_cnt;
    tx_exp.push_back(8'h15);
    push_frame(h, 3, 1'b0);
    pulse_start();
    wait_done("timeout", tx0 + 1, cyc);
    check("timeout_not_early", 32'(cyc > TMO), 1);
    check("timeout_err", 32'(err), 1);
    check("timeout_done", 32'(done), 0);
    check("timeout_busy", 32'(busy), 0);

    // Reset in the middle of the data phase, then a clean reload.
    h = mk(32'h0000_0700, 2, 32'h5555_AAAA, 32'h6666_BBBB, 8'h00, 0, 0, 8'h06, 1, 0, 1);
    push_frame(h, -1, 1'b0);
    pulse_start();
    n = 0;
    while (n < 2000 && rx_q.size() > 6) begin @(negedge clk); n++; end
    check("midreset_reached_data", 32'(n < 2000), 1);
    @(posedge clk); #1 rst_l = 1'b0;
    @(negedge clk);
    check_reset("midreset");
    rx_q.delete();
    repeat (2) @(negedge clk);
    tx0 = tx_cnt; clr0 = clr_cnt;
    @(posedge clk); #1 rst_l = 1'b1;
    h = mk(32'h0000_0800, 1, 32'h0BAD_CAFE, 32'h0, 8'h00, 0, 0, 8'h06, 1, 0, 1);
    tx_exp.push_back(8'h06);
    push_frame(h, -1, 1'b1);
    wait_done("after_reset", tx0 + 1, cyc);
    check("after_reset_tx_count", 32'(tx_cnt - tx0), 1);
    check("after_reset_clr_count", 32'(clr_cnt - clr0), 1);
    check("after_reset_done", 32'(done), 1);
    check("after_reset_cpu_run", 32'(cpu_run), 1);
    check("after_reset_mem_left", 32'(mem_exp.size()), 0);

    check("tx_left", 32'(tx_exp.size()), 0);
    check("bus_protocol", 32'(viol), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
